// File: rtl/class_hvec_store.sv
// Writable class-hypervector memory with a frame-wise write port and a
// valid/ready read-out stream of one class or all classes in order.
module class_hvec_store #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    localparam int CLASS_W           = $clog2(NUM_CLASSES),
    localparam int FRAME_W           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [CLASS_W-1:0]            wr_class,
    input  logic [FRAME_W-1:0]            wr_frame,
    input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CLASS_W-1:0]            req_class,
    input  logic                          req_all,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic [CLASS_W-1:0]            out_class,
    output logic [FRAME_W-1:0]            out_frame,
    output logic                          out_last_frame,
    output logic                          out_last,
    output logic                          err
);

    localparam int DEPTH  = NUM_CLASSES * NUM_FRAMES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    state_t               state;
    logic [CLASS_W-1:0]   cls;
    logic [FRAME_W-1:0]   frm;
    logic                 all_mode;
    logic                 wr_ok;

    logic [DI_PARALLEL_W_BITS-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CLASS_W-1:0] c,
                                                  input logic [FRAME_W-1:0] f);
        return ADDR_W'(c) * ADDR_W'(NUM_FRAMES) + ADDR_W'(f);
    endfunction

    // Out-of-range writes would alias onto other entries, so they are dropped.
    assign wr_ok = wr_en && (32'(wr_class) < NUM_CLASSES) && (32'(wr_frame) < NUM_FRAMES);

    // NOTE: the array has no reset; trained vectors must survive rst, and a
    // write in the reset cycle still lands.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[addr_of(wr_class, wr_frame)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cls            <= '0;
            frm            <= '0;
            all_mode       <= 1'b0;
            req_ready      <= 1'b1;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_class      <= '0;
            out_frame      <= '0;
            out_last_frame <= 1'b0;
            out_last       <= 1'b0;
            err            <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_all) begin
                            cls       <= '0;
                            frm       <= '0;
                            all_mode  <= 1'b1;
                            req_ready <= 1'b0;
                            state     <= FETCH;
                        end else if (32'(req_class) < NUM_CLASSES) begin
                            cls       <= req_class;
                            frm       <= '0;
                            all_mode  <= 1'b0;
                            req_ready <= 1'b0;
                            state     <= FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // NOTE: this read and a same-edge write both use <=, so the
                    // beat carries the pre-write contents (read-first).
                    out_data       <= mem[addr_of(cls, frm)];
                    out_class      <= cls;
                    out_frame      <= frm;
                    out_last_frame <= (frm == LAST_FRAME);
                    out_last       <= (frm == LAST_FRAME) && (!all_mode || cls == LAST_CLASS);
                    out_valid      <= 1'b1;
                    state          <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (frm == LAST_FRAME) begin
                                frm <= '0;
                                cls <= cls + CLASS_W'(1);
                            end else begin
                                frm <= frm + FRAME_W'(1);
                            end
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
